axi4_lite_write_arbiter: RTL and testbench
==========================================

AXI4_LITE_WRITE_ARBITER -- requirements
Module: axi4_lite_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one AXI4-Lite write master port (legal range 2..8).
REQ-002 SHALL have parameter ADDR_SIZE, default 2, write address width.
REQ-003 SHALL have parameter DATA_SIZE, default 32, data width; strobe width is DATA_SIZE/8.
REQ-004 SHALL have ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_clk_ni  in  1  synchronous, active-low reset.
- req_address_i  in  NUM_REQ*ADDR_SIZE  packed per-requester address; requester k at slice k.
- req_data_i  in  NUM_REQ*DATA_SIZE  packed per-requester data.
- req_strb_i  in  NUM_REQ*DATA_SIZE/8  packed per-requester strobes.
- req_valid_i  in  NUM_REQ  requester k has a pending write.
- req_ready_o  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- req_response_o  out  2  captured BRESP, shared by all requesters.
- req_response_valid_o  out  NUM_REQ  response valid to the granted requester.
- req_response_ready_i  in  NUM_REQ  requester k accepts the response.
- write_address_o  out  ADDR_SIZE;  write_address_valid_o  out  1;  write_address_ready_i  in  1.
- write_data_o  out  DATA_SIZE;  write_data_strb_o  out  DATA_SIZE/8;  write_data_valid_o  out  1;  write_data_ready_i  in  1.
- write_response_i  in  2;  write_response_valid_i  in  1;  write_response_ready_o  out  1.
- grant_o  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy_o  out  1  high in every state except IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT_B, RESP; exactly one transaction in flight.
REQ-006 In IDLE with any req_valid_i high, SHALL grant by round-robin: first valid index at or after pointer ptr, wrapping modulo NUM_REQ.
REQ-007 On grant edge SHALL register the winner's address/data/strobe, set grant_o, pulse req_ready_o[grant] high for exactly the next cycle, and enter ISSUE.
REQ-008 In ISSUE SHALL assert write_address_valid_o and write_data_valid_o together from the first ISSUE cycle; payload is held stable until the handshake completes.
REQ-009 Each of AW and W SHALL deassert on the cycle after its own valid&ready handshake, independently, in either order or the same cycle.
REQ-010 SHALL leave ISSUE for WAIT_B on the edge where both AW and W have handshaken (done flags or same-cycle handshakes).
REQ-011 In WAIT_B SHALL hold write_response_ready_o high; on write_response_valid_i SHALL capture write_response_i into req_response_o and enter RESP.
REQ-012 write_response_ready_o SHALL be low in all states other than WAIT_B; write_response_valid_i outside WAIT_B SHALL be ignored.
REQ-013 In RESP SHALL assert req_response_valid_o[grant] only, holding req_response_o stable until req_response_ready_i[grant] is high.
REQ-014 On RESP handshake SHALL return to IDLE and set ptr = (grant+1) mod NUM_REQ; a new grant is possible in the following IDLE cycle.
REQ-015 Minimum transaction SHALL be 4 cycles from grant edge to IDLE with all readies constantly high.
REQ-016 Changes to req_valid_i or to non-granted requesters' inputs outside IDLE SHALL have no effect.
REQ-017 Responses SHALL pass through unmodified (OKAY 2'b00, SLVERR 2'b10, any code).

Reset
REQ-018 On rst_clk_ni low at a rising edge, SHALL enter IDLE, ptr=0, grant_o=0, and drive all valid/ready outputs, req_response_o, write_address_o, write_data_o and write_data_strb_o to 0; busy_o=0.
REQ-019 Reset mid-transaction SHALL abandon it at once with no response to the requester; the next grant follows REQ-006 from ptr=0.

Verification
REQ-020 Single write: req_valid_i=01, address 2, data 0xDEADBEEF, strb 0xF, all readies high -> AW/W valid one cycle with those values, req_response_valid_o=01 with 2'b00, IDLE 4 cycles after grant.
REQ-021 Round-robin: req_valid_i=11 held for three transactions -> grants 0,1,0; req_ready_o pulses 01,10,01.
REQ-022 Split handshake: write_address_ready_i high at ISSUE cycle 1, write_data_ready_i high only at cycle 3 -> AW valid for 1 cycle, W for 3, WAIT_B entered after the W handshake.
REQ-023 Response backpressure: BRESP 2'b10, req_response_ready_i low for 5 cycles -> req_response_o=2'b10 and valid held 5 cycles; no new grant meanwhile despite the other requester valid.
REQ-024 Reset in WAIT_B: rst_clk_ni low one cycle -> all outputs zero next cycle, busy_o=0, later req_valid_i=10 granted to requester 1 normally.

Source files
------------

// File: rtl/axi4_lite_write_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite write master port among NUM_REQ requesters.
// One transaction is in flight at a time; the AW and W channels are issued together and may complete in either order.
module axi4_lite_write_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = 2,
  parameter int DATA_SIZE = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_clk_ni,

  input  logic [NUM_REQ*ADDR_SIZE-1:0]      req_address_i,
  input  logic [NUM_REQ*DATA_SIZE-1:0]      req_data_i,
  input  logic [NUM_REQ*(DATA_SIZE/8)-1:0]  req_strb_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [1:0]                        req_response_o,
  output logic [NUM_REQ-1:0]                req_response_valid_o,
  input  logic [NUM_REQ-1:0]                req_response_ready_i,

  output logic [ADDR_SIZE-1:0]              write_address_o,
  output logic                              write_address_valid_o,
  input  logic                              write_address_ready_i,

  output logic [DATA_SIZE-1:0]              write_data_o,
  output logic [DATA_SIZE/8-1:0]            write_data_strb_o,
  output logic                              write_data_valid_o,
  input  logic                              write_data_ready_i,

  input  logic [1:0]                        write_response_i,
  input  logic                              write_response_valid_i,
  output logic                              write_response_ready_o,

  output logic [$clog2(NUM_REQ)-1:0]        grant_o,
  output logic                              busy_o
);

  localparam int STRB_SIZE  = DATA_SIZE / 8;
  localparam int GRANT_SIZE = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_B = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                  state;
  logic [GRANT_SIZE-1:0]   ptr;
  logic [GRANT_SIZE-1:0]   grant_inc;

  logic [2*NUM_REQ-1:0]    valid_dbl;
  logic [NUM_REQ-1:0]      valid_rot;
  logic [GRANT_SIZE-1:0]   pick_idx;
  logic                    pick_found;
  int                      pick_sum;

  logic                    aw_fin;
  logic                    w_fin;

  // Rotating the doubled request vector by ptr puts the highest-priority requester at bit 0.
  assign valid_dbl = {req_valid_i, req_valid_i};
  assign valid_rot = NUM_REQ'(valid_dbl >> ptr);

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_sum   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && valid_rot[i]) begin
        pick_found = 1'b1;
        pick_sum   = int'(ptr) + i;
        if (pick_sum >= NUM_REQ) begin
          pick_sum = pick_sum - NUM_REQ;
        end
        pick_idx = GRANT_SIZE'(pick_sum);
      end
    end
  end

  assign grant_inc = (grant_o == GRANT_SIZE'(NUM_REQ - 1)) ? '0 : grant_o + GRANT_SIZE'(1);

  // A channel counts as finished once its valid has dropped or it handshakes this cycle.
  assign aw_fin = !write_address_valid_o || write_address_ready_i;
  assign w_fin  = !write_data_valid_o || write_data_ready_i;

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_clk_ni) begin
      state                  <= IDLE;
      ptr                    <= '0;
      grant_o                <= '0;
      req_ready_o            <= '0;
      req_response_o         <= 2'b00;
      req_response_valid_o   <= '0;
      write_address_o        <= '0;
      write_address_valid_o  <= 1'b0;
      write_data_o           <= '0;
      write_data_strb_o      <= '0;
      write_data_valid_o     <= 1'b0;
      write_response_ready_o <= 1'b0;
    end else begin
      req_ready_o <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_o               <= pick_idx;
            write_address_o       <= req_address_i[pick_idx*ADDR_SIZE +: ADDR_SIZE];
            write_data_o          <= req_data_i[pick_idx*DATA_SIZE +: DATA_SIZE];
            write_data_strb_o     <= req_strb_i[pick_idx*STRB_SIZE +: STRB_SIZE];
            req_ready_o           <= NUM_REQ'(1) << pick_idx;
            write_address_valid_o <= 1'b1;
            write_data_valid_o    <= 1'b1;
            state                 <= ISSUE;
          end
        end
        ISSUE: begin
          if (write_address_valid_o && write_address_ready_i) begin
            write_address_valid_o <= 1'b0;
          end
          if (write_data_valid_o && write_data_ready_i) begin
            write_data_valid_o <= 1'b0;
          end
          if (aw_fin && w_fin) begin
            write_response_ready_o <= 1'b1;
            state                  <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (write_response_valid_i) begin
            req_response_o         <= write_response_i;
            write_response_ready_o <= 1'b0;
            req_response_valid_o   <= NUM_REQ'(1) << grant_o;
            state                  <= RESP;
          end
        end
        RESP: begin
          if (|(req_response_valid_o & req_response_ready_i)) begin
            req_response_valid_o <= '0;
            ptr                  <= grant_inc;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_write_arbiter.sv
// Directed self-checking bench for axi4_lite_write_arbiter with two requesters.
// Expected values are hand-derived from the cycle timing: grant edge, ISSUE, WAIT_B, RESP, then IDLE.
module tb_axi4_lite_write_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_clk_ni;
  logic [3:0]  req_address_i;
  logic [63:0] req_data_i;
  logic [7:0]  req_strb_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  req_response_o;
  logic [1:0]  req_response_valid_o;
  logic [1:0]  req_response_ready_i;
  logic [1:0]  write_address_o;
  logic        write_address_valid_o;
  logic        write_address_ready_i;
  logic [31:0] write_data_o;
  logic [3:0]  write_data_strb_o;
  logic        write_data_valid_o;
  logic        write_data_ready_i;
  logic [1:0]  write_response_i;
  logic        write_response_valid_i;
  logic        write_response_ready_o;
  logic [0:0]  grant_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  axi4_lite_write_arbiter #(
    .NUM_REQ(2),
    .ADDR_SIZE(2),
    .DATA_SIZE(32)
  ) dut (
    .clk_i(clk_i),
    .rst_clk_ni(rst_clk_ni),
    .req_address_i(req_address_i),
    .req_data_i(req_data_i),
    .req_strb_i(req_strb_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_response_o(req_response_o),
    .req_response_valid_o(req_response_valid_o),
    .req_response_ready_i(req_response_ready_i),
    .write_address_o(write_address_o),
    .write_address_valid_o(write_address_valid_o),
    .write_address_ready_i(write_address_ready_i),
    .write_data_o(write_data_o),
    .write_data_strb_o(write_data_strb_o),
    .write_data_valid_o(write_data_valid_o),
    .write_data_ready_i(write_data_ready_i),
    .write_response_i(write_response_i),
    .write_response_valid_i(write_response_valid_i),
    .write_response_ready_o(write_response_ready_o),
    .grant_o(grant_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it, so outputs are sampled away from the edge.
  task automatic stepClock();
    @(posedge clk_i);
    #1;
  endtask

  // Requester 0: addr 2, data DEADBEEF, strb F; requester 1: addr 1, data 11111111, strb 3.
  task automatic applyStimulus(input logic [1:0] valid);
    req_address_i = {2'd1, 2'd2};
    req_data_i    = {32'h1111_1111, 32'hDEAD_BEEF};
    req_strb_i    = {4'h3, 4'hF};
    req_valid_i   = valid;
  endtask

  task automatic resetDut();
    rst_clk_ni = 1'b0;
    stepClock();
    stepClock();
    rst_clk_ni = 1'b1;
  endtask

  // Full transaction with every ready high and BVALID already waiting; starts in IDLE with requests applied.
  task automatic runTxn(input string tag, input logic exp_grant, input logic [1:0] exp_resp);
    logic [1:0]  exp_onehot;
    logic [1:0]  exp_addr;
    logic [31:0] exp_data;
    exp_onehot = exp_grant ? 2'b10 : 2'b01;
    exp_addr   = exp_grant ? 2'd1 : 2'd2;
    exp_data   = exp_grant ? 32'h1111_1111 : 32'hDEAD_BEEF;
    stepClock();
    checkOutput({tag, "_grant"}, 64'(grant_o), 64'(exp_grant));
    checkOutput({tag, "_ready"}, 64'(req_ready_o), 64'(exp_onehot));
    checkOutput({tag, "_addr"}, 64'(write_address_o), 64'(exp_addr));
    checkOutput({tag, "_data"}, 64'(write_data_o), 64'(exp_data));
    stepClock();
    checkOutput({tag, "_bready"}, 64'(write_response_ready_o), 64'd1);
    checkOutput({tag, "_ready_pulse_end"}, 64'(req_ready_o), 64'd0);
    stepClock();
    checkOutput({tag, "_rvalid"}, 64'(req_response_valid_o), 64'(exp_onehot));
    checkOutput({tag, "_resp"}, 64'(req_response_o), 64'(exp_resp));
    stepClock();
    checkOutput({tag, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    rst_clk_ni             = 1'b0;
    applyStimulus(2'b00);
    req_response_ready_i   = 2'b11;
    write_address_ready_i  = 1'b1;
    write_data_ready_i     = 1'b1;
    write_response_i       = 2'b00;
    write_response_valid_i = 1'b1;
    resetDut();

    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_grant", 64'(grant_o), 64'd0);
    checkOutput("rst_outs", 64'({req_ready_o, req_response_valid_o, req_response_o,
                                 write_address_valid_o, write_data_valid_o, write_response_ready_o}), 64'd0);
    checkOutput("rst_payload", 64'({write_address_o, write_data_o, write_data_strb_o}), 64'd0);

    // Single write from requester 0.
    applyStimulus(2'b01);
    stepClock();
    checkOutput("single_ready", 64'(req_ready_o), 64'b01);
    checkOutput("single_awvalid", 64'(write_address_valid_o), 64'd1);
    checkOutput("single_wvalid", 64'(write_data_valid_o), 64'd1);
    checkOutput("single_addr", 64'(write_address_o), 64'd2);
    checkOutput("single_data", 64'(write_data_o), 64'hDEAD_BEEF);
    checkOutput("single_strb", 64'(write_data_strb_o), 64'hF);
    checkOutput("single_busy", 64'(busy_o), 64'd1);
    checkOutput("single_bready_issue", 64'(write_response_ready_o), 64'd0);
    req_valid_i = 2'b00;
    stepClock();
    checkOutput("single_aw_drop", 64'({write_address_valid_o, write_data_valid_o}), 64'd0);
    checkOutput("single_bready", 64'(write_response_ready_o), 64'd1);
    stepClock();
    checkOutput("single_rvalid", 64'(req_response_valid_o), 64'b01);
    checkOutput("single_resp", 64'(req_response_o), 64'b00);
    checkOutput("single_bready_low", 64'(write_response_ready_o), 64'd0);
    stepClock();
    checkOutput("single_idle", 64'(busy_o), 64'd0);
    checkOutput("single_rvalid_low", 64'(req_response_valid_o), 64'd0);

    // Round-robin from ptr 0 with both requesters continuously valid.
    resetDut();
    applyStimulus(2'b11);
    runTxn("rr0", 1'b0, 2'b00);
    runTxn("rr1", 1'b1, 2'b00);
    runTxn("rr2", 1'b0, 2'b00);

    // Split handshake: AW accepted in ISSUE cycle 1, W only in cycle 3; BVALID arrives late.
    applyStimulus(2'b01);
    write_data_ready_i     = 1'b0;
    write_response_valid_i = 1'b0;
    stepClock();
    checkOutput("split_grant", 64'(grant_o), 64'd0);
    checkOutput("split_valids_c1", 64'({write_address_valid_o, write_data_valid_o}), 64'b11);
    req_valid_i = 2'b00;
    stepClock();
    checkOutput("split_valids_c2", 64'({write_address_valid_o, write_data_valid_o}), 64'b01);
    checkOutput("split_bready_c2", 64'(write_response_ready_o), 64'd0);
    write_address_ready_i = 1'b0;
    stepClock();
    checkOutput("split_valids_c3", 64'({write_address_valid_o, write_data_valid_o}), 64'b01);
    checkOutput("split_bready_c3", 64'(write_response_ready_o), 64'd0);
    write_data_ready_i = 1'b1;
    stepClock();
    checkOutput("split_valids_done", 64'({write_address_valid_o, write_data_valid_o}), 64'b00);
    checkOutput("split_bready_waitb", 64'(write_response_ready_o), 64'd1);
    stepClock();
    checkOutput("split_bwait_hold", 64'({write_response_ready_o, req_response_valid_o}), 64'b100);
    write_address_ready_i  = 1'b1;
    write_response_i       = 2'b01;
    write_response_valid_i = 1'b1;
    stepClock();
    checkOutput("split_rvalid", 64'(req_response_valid_o), 64'b01);
    checkOutput("split_resp", 64'(req_response_o), 64'b01);
    stepClock();
    checkOutput("split_idle", 64'(busy_o), 64'd0);

    // Response backpressure: ptr is 1, so requester 1 wins while requester 0 keeps waiting.
    applyStimulus(2'b11);
    write_response_i     = 2'b10;
    req_response_ready_i = 2'b00;
    stepClock();
    checkOutput("bp_grant", 64'(grant_o), 64'd1);
    checkOutput("bp_ready", 64'(req_ready_o), 64'b10);
    stepClock();
    stepClock();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rvalid_hold", 64'(req_response_valid_o), 64'b10);
      checkOutput("bp_resp_hold", 64'(req_response_o), 64'b10);
      checkOutput("bp_no_new_grant", 64'({req_ready_o, grant_o}), 64'b001);
      if (i < 4) stepClock();
    end
    req_response_ready_i = 2'b11;
    stepClock();
    checkOutput("bp_idle", 64'(busy_o), 64'd0);
    checkOutput("bp_rvalid_low", 64'(req_response_valid_o), 64'd0);
    stepClock();
    checkOutput("bp_next_grant", 64'(grant_o), 64'd0);
    checkOutput("bp_next_ready", 64'(req_ready_o), 64'b01);
    req_valid_i = 2'b00;
    stepClock();
    checkOutput("rstb_in_waitb", 64'(write_response_ready_o), 64'd1);

    // Reset while in WAIT_B with BVALID present: transaction abandoned, no response.
    rst_clk_ni = 1'b0;
    stepClock();
    rst_clk_ni = 1'b1;
    checkOutput("rstb_busy", 64'(busy_o), 64'd0);
    checkOutput("rstb_grant", 64'(grant_o), 64'd0);
    checkOutput("rstb_outs", 64'({req_ready_o, req_response_valid_o, req_response_o,
                                  write_address_valid_o, write_data_valid_o, write_response_ready_o}), 64'd0);
    checkOutput("rstb_payload", 64'({write_address_o, write_data_o, write_data_strb_o}), 64'd0);
    stepClock();
    checkOutput("rstb_no_resp", 64'({req_response_valid_o, busy_o}), 64'd0);
    applyStimulus(2'b10);
    runTxn("rstb_after", 1'b1, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
